// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge filter between two FWFT FIFOs
// SOBEL_GRAY_CONV_EN: gray = (r+g+b)/3; otherwise gray = in_dout[7:0].
module sobel_stream #(
    parameter int WIDTH     = 720,
    parameter int HEIGHT    = 720,
    parameter int THRESHOLD = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        in_rd_en,
    input  logic [23:0] in_dout,
    input  logic        in_empty,
    output logic        out_wr_en,
    output logic [7:0]  out_din,
    input  logic        out_full
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d, ocol_q, ocol_d;
    logic [RW-1:0]       row_q, row_d, orow_q, orow_d;
    logic                valid_q, valid_d;
    logic [7:0]          data_q, data_d;
    logic [2:0][1:0][7:0] win_q, win_d;
    logic [7:0]          lb1_q [WIDTH];
    logic [7:0]          lb2_q [WIDTH];
    logic [2:0][2:0][7:0] w;
    logic [7:0]          gray;
    logic                can_load, accept, load, border;
    logic [7:0]          load_val, pix_res, sat;
    logic signed [10:0]  gx, gy;
    logic [10:0]         ax, ay;
    logic [11:0]         mag;

`ifdef SOBEL_GRAY_CONV_EN
    logic [9:0] rgb_sum;
    assign rgb_sum = 10'(in_dout[23:16]) + 10'(in_dout[15:8]) + 10'(in_dout[7:0]);
    assign gray    = 8'(rgb_sum / 10'd3);
`else
    logic unused_rg;
    assign unused_rg = ^in_dout[23:8];
    assign gray      = in_dout[7:0];
`endif

    function automatic logic signed [10:0] sx(input logic [7:0] v);
        return signed'({3'b000, v});
    endfunction

    assign can_load  = !valid_q || !out_full;
    assign accept    = !rst && !in_empty && can_load && (state_q != FLUSH);
    assign in_rd_en  = accept;
    assign out_wr_en = !rst && valid_q && !out_full;
    assign out_din   = rst ? 8'd0 : data_q;

    // Full window = two registered columns plus the column arriving this cycle.
    always_comb begin
        w     = '0;
        win_d = '0;
        for (int r = 0; r < 3; r++) begin
            w[r][0]     = win_q[r][0];
            w[r][1]     = win_q[r][1];
            win_d[r][0] = win_q[r][1];
        end
        w[0][2] = lb2_q[col_q];
        w[1][2] = lb1_q[col_q];
        w[2][2] = gray;
        for (int r = 0; r < 3; r++) win_d[r][1] = w[r][2];
    end

    always_comb begin
        gx = (sx(w[0][2]) + sx(w[1][2]) + sx(w[1][2]) + sx(w[2][2]))
           - (sx(w[0][0]) + sx(w[1][0]) + sx(w[1][0]) + sx(w[2][0]));
        gy = (sx(w[2][0]) + sx(w[2][1]) + sx(w[2][1]) + sx(w[2][2]))
           - (sx(w[0][0]) + sx(w[0][1]) + sx(w[0][1]) + sx(w[0][2]));
        ax  = gx[10] ? 11'(-gx) : 11'(gx);
        ay  = gy[10] ? 11'(-gy) : 11'(gy);
        mag = {1'b0, ax} + {1'b0, ay};
        sat = (mag > 12'd255) ? 8'hFF : mag[7:0];
        border = (orow_q == '0) || (orow_q == ROW_LAST) || (ocol_q == '0) || (ocol_q == COL_LAST);
        if (border)
            pix_res = 8'd0;
        else if (THRESHOLD == 0)
            pix_res = sat;
        else
            pix_res = (int'(sat) >= THRESHOLD) ? 8'hFF : 8'd0;
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        ocol_d   = ocol_q;
        orow_d   = orow_q;
        valid_d  = valid_q && out_full;
        data_d   = data_q;
        load     = 1'b0;
        load_val = 8'd0;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            case (state_q)
                FILL: if (row_q == RW'(1) && col_q == '0) state_d = RUN;
                RUN: begin
                    load     = 1'b1;
                    load_val = pix_res;
                    if (row_q == ROW_LAST && col_q == COL_LAST) state_d = FLUSH;
                end
                default: ;
            endcase
        end else if (state_q == FLUSH && can_load && !rst) begin
            load = 1'b1;
        end
        // Output-side counters track which pixel the output register holds.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_val;
            if (ocol_q == COL_LAST) begin
                ocol_d = '0;
                orow_d = (orow_q == ROW_LAST) ? '0 : orow_q + RW'(1);
            end else begin
                ocol_d = ocol_q + CW'(1);
            end
            if (state_q == FLUSH && orow_q == ROW_LAST && ocol_q == COL_LAST) state_d = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            ocol_q  <= '0;
            orow_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ocol_q  <= ocol_d;
            orow_q  <= orow_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= gray;
            lb2_q[col_q] <= lb1_q[col_q];
            win_q        <= win_d;
        end
    end
endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - scoreboard bench for sobel_stream on 8x8 frames
module tb_sobel_stream;
    localparam int W = 8;
    localparam int H = 8;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst, in_empty, out_full;
    logic [23:0] in_dout, in_dout_t;
    logic        in_rd_en, out_wr_en, in_rd_en_t, out_wr_en_t;
    logic [7:0]  out_din, out_din_t;

    always #5 clk = ~clk;

    sobel_stream #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(0)) dut (
        .clk(clk), .rst(rst), .in_rd_en(in_rd_en), .in_dout(in_dout), .in_empty(in_empty),
        .out_wr_en(out_wr_en), .out_din(out_din), .out_full(out_full));

    sobel_stream #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(128)) dut_t (
        .clk(clk), .rst(rst), .in_rd_en(in_rd_en_t), .in_dout(in_dout_t), .in_empty(in_empty),
        .out_wr_en(out_wr_en_t), .out_din(out_din_t), .out_full(out_full));

    typedef struct {
        logic [23:0] d;
        logic [23:0] dt;
    } pix_t;

    typedef struct {
        int r;
        int c;
        int em;
        int et;
    } vec_t;

    pix_t fifo[$];
    int   q_m[$], q_t[$], log_m[$], log_t[$];
    int   gimg[H][W];
    int   timg[H][W];
    int   pass_cnt = 0, total_cnt = 0, cyc = 0;
    int   acc_phase = 0, out_phase = 0;
    int   first_acc = 0, acc9 = 0, last_acc = 0, last_acc2 = 0, first_wr = 0;
    bit   gap_mode = 0, hold = 0, hold_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int ref_px(input int which, input int r, input int c);
        int p[3][3];
        int gx, gy, m;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = (which == 1) ? timg[r-1+i][c-1+j] : gimg[r-1+i][c-1+j];
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
        if (which == 1) m = (m >= 128) ? 255 : 0;
        return m;
    endfunction

    // kind 0: flat RGB(100,100,100); kind 1: black left half, white right half.
    task automatic load_frame(input int kind);
        pix_t p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int v, tv;
                v  = (kind == 0) ? 100 : ((c >= 4) ? 255 : 0);
                tv = (c >= 4) ? 40 : 0;
                gimg[r][c] = v;
                timg[r][c] = tv;
                p.d = {8'(v), 8'(v), 8'(v)};
`ifdef SOBEL_GRAY_CONV_EN
                p.dt = {8'(tv), 8'(tv), 8'(tv)};
`else
                p.dt = {16'hFFFF, 8'(tv)};
`endif
                fifo.push_back(p);
            end
        end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                q_m.push_back(ref_px(0, r, c));
                q_t.push_back(ref_px(1, r, c));
            end
    endtask

    task automatic start_phase();
        @(posedge clk);
        #2;
        acc_phase = 0;
        out_phase = 0;
        log_m.delete();
        log_t.delete();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q_m.size() != 0 || q_t.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_drain"}, q_m.size() + q_t.size(), 0);
        repeat (20) @(posedge clk);
    endtask

    // Upstream FWFT FIFO model.
    initial begin
        bit rd_seen;
        in_empty  = 1'b1;
        in_dout   = '0;
        in_dout_t = '0;
        forever begin
            @(negedge clk);
            rd_seen = in_rd_en;
            @(posedge clk);
            #1;
            if (rd_seen && fifo.size() > 0) fifo.delete(0);
            in_empty = (fifo.size() == 0) || (gap_mode && ($urandom_range(1, 0) == 1));
            if (fifo.size() > 0) begin
                in_dout   = fifo[0].d;
                in_dout_t = fifo[0].dt;
            end
        end
    end

    // Output monitor and scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (hold && (in_rd_en || out_wr_en)) hold_bad = 1;
            if (in_rd_en) begin
                if (acc_phase == 0) first_acc = cyc;
                if (acc_phase == W + 1) acc9 = cyc;
                if (acc_phase == NPIX - 1) last_acc = cyc;
                if (acc_phase == 2 * NPIX - 1) last_acc2 = cyc;
                acc_phase++;
            end
            if (out_wr_en) begin
                if (out_phase == 0) first_wr = cyc;
                out_phase++;
                log_m.push_back(int'(out_din));
                chk("sb_m_pending", int'(q_m.size() > 0), 1);
                if (q_m.size() > 0) chk("sb_m_pix", int'(out_din), q_m.pop_front());
            end
            if (out_wr_en_t) begin
                log_t.push_back(int'(out_din_t));
                chk("sb_t_pending", int'(q_t.size() > 0), 1);
                if (q_t.size() > 0) chk("sb_t_pix", int'(out_din_t), q_t.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        int n;
        tbl[0] = '{0, 3, 0, 0};
        tbl[1] = '{1, 3, 255, 255};
        tbl[2] = '{1, 4, 255, 255};
        tbl[3] = '{3, 3, 255, 255};
        tbl[4] = '{6, 4, 255, 255};
        tbl[5] = '{7, 4, 0, 0};
        tbl[6] = '{3, 0, 0, 0};
        tbl[7] = '{3, 2, 0, 0};
        tbl[8] = '{3, 5, 0, 0};
        tbl[9] = '{4, 7, 0, 0};

        rst = 1'b1;
        out_full = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        load_frame(0);
        load_frame(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_empty_low", int'(in_empty), 0);
        chk("rst_rd_en", int'(in_rd_en), 0);
        chk("rst_wr_en", int'(out_wr_en), 0);
        chk("rst_din", int'(out_din), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        acc_phase = 0;
        out_phase = 0;
        wait_drain("flat");
        chk("flat_count", log_m.size(), 2 * NPIX);
        chk("flat_count_t", log_t.size(), 2 * NPIX);
        chk("flat_thruput", last_acc - first_acc, NPIX - 1);
        chk("b2b_thruput", last_acc2 - first_acc, 2 * NPIX - 1 + W + 1);
        chk("first_latency", first_wr - acc9, 1);

        start_phase();
        load_frame(1);
        wait_drain("step");
        chk("step_count", log_m.size(), NPIX);
        for (int i = 0; i < 10; i++) begin
            int idx, am, at;
            idx = tbl[i].r * W + tbl[i].c;
            am = (idx < log_m.size()) ? log_m[idx] : -1;
            at = (idx < log_t.size()) ? log_t[idx] : -1;
            chk($sformatf("tbl%0d_r%0dc%0d_mag", i, tbl[i].r, tbl[i].c), am, tbl[i].em);
            chk($sformatf("tbl%0d_r%0dc%0d_thr", i, tbl[i].r, tbl[i].c), at, tbl[i].et);
        end

        start_phase();
        load_frame(1);
        n = 0;
        while (out_phase < 30 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("hold_reach30", int'(out_phase >= 30), 1);
        #2;
        out_full = 1'b1;
        hold = 1;
        repeat (20) @(posedge clk);
        #2;
        out_full = 1'b0;
        hold = 0;
        chk("hold_quiet", int'(hold_bad), 0);
        wait_drain("hold");
        chk("hold_count", log_m.size(), NPIX);

        start_phase();
        gap_mode = 1;
        load_frame(1);
        load_frame(1);
        wait_drain("gaps");
        gap_mode = 0;
        chk("gaps_count", log_m.size(), 2 * NPIX);
        chk("gaps_count_t", log_t.size(), 2 * NPIX);

        start_phase();
        load_frame(1);
        n = 0;
        while (acc_phase < 30 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("mid_reach30", acc_phase, 30);
        #2;
        rst = 1'b1;
        fifo.delete();
        q_m.delete();
        q_t.delete();
        @(negedge clk);
        chk("mid_rst_rd_en", int'(in_rd_en), 0);
        chk("mid_rst_wr_en", int'(out_wr_en), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_en", int'(out_wr_en), 0);
        start_phase();
        load_frame(1);
        wait_drain("after_rst");
        chk("after_rst_count", log_m.size(), NPIX);
        chk("after_rst_count_t", log_t.size(), NPIX);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 Parameter WIDTH, default 720, image width in pixels; legal range 3..4096.
REQ-002 Parameter HEIGHT, default 720, image height in pixels; legal range 3..4096.
REQ-003 Parameter THRESHOLD, default 0: 0 = magnitude output; 1..255 = binary output (255 if magnitude >= THRESHOLD, else 0).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_rd_en  output  1  pop strobe to the upstream first-word-fall-through FIFO.
REQ-007 in_dout  input  24  upstream FIFO head word {r[23:16], g[15:8], b[7:0]}; valid while in_empty=0.
REQ-008 in_empty  input  1  upstream FIFO empty flag.
REQ-009 out_wr_en  output  1  push strobe to the downstream FIFO.
REQ-010 out_din  output  8  edge pixel written when out_wr_en=1.
REQ-011 out_full  input  1  downstream FIFO full flag.

Function
REQ-012 Pixels arrive in raster order (row 0 col 0 first); exactly WIDTH*HEIGHT outputs are produced per frame, in raster order, one per input pixel.
REQ-013 Input pixels are converted to 8-bit gray: gray = (r+g+b)/3, 10-bit sum, truncating divide.
REQ-014 Two WIDTH-deep 8-bit line buffers plus a 3x3 window register hold the neighbourhood; line buffers are never cleared.
REQ-015 Gx = (p02+2*p12+p22) - (p00+2*p10+p20); Gy = (p20+2*p21+p22) - (p00+2*p01+p02); signed 11-bit arithmetic, no overflow.
REQ-016 Magnitude = |Gx|+|Gy|, saturated to 255; THRESHOLD then applied per REQ-003.
REQ-017 Border pixels (row 0, row HEIGHT-1, col 0, col WIDTH-1) output 0 regardless of content.
REQ-018 One-entry output register with valid flag; out_wr_en = valid AND NOT out_full; out_din = register contents.
REQ-019 Input accepted (in_rd_en=1) only when in_empty=0 AND (valid=0 OR out_full=0) AND state is FILL or RUN; in_rd_en is combinational from these terms.
REQ-020 States: FILL, RUN, FLUSH.
REQ-021 FILL: first WIDTH+1 accepted pixels of a frame are consumed with no output; on the (WIDTH+1)th accept -> RUN.
REQ-022 RUN: each accept loads output register with result for pixel index k-(WIDTH+1), k = index of the accepted pixel; on accept of the last pixel (index WIDTH*HEIGHT-1) -> FLUSH.
REQ-023 FLUSH: in_rd_en=0; emits the remaining WIDTH+1 outputs, all 0 (all are border pixels), one per cycle when the output register can load; after the last one -> FILL, with row/col counters at 0 for the next frame.
REQ-024 Latency: out_wr_en for a given output asserts no earlier than the cycle after the load, and in that cycle if out_full=0.
REQ-025 Throughput: one pixel per cycle sustained when in_empty=0 and out_full=0, including across frame boundaries apart from the WIDTH+1 FLUSH cycles.
REQ-026 Simultaneous load and drain of the output register in one cycle is legal; no output is dropped or duplicated under any in_empty/out_full pattern.
REQ-027 Row/column counters wrap col WIDTH-1 -> 0 with row increment; row HEIGHT-1/col WIDTH-1 marks end of frame.

Reset
REQ-028 rst=1 forces state FILL, counters 0, valid 0, out_din 0, out_wr_en 0, in_rd_en 0 in the same cycle rst is sampled and while held.
REQ-029 Reset mid-frame discards the partial frame and any pending output; the first pixel accepted after reset is row 0 col 0.

Configuration
REQ-030 Macro SOBEL_GRAY_CONV_EN defined: gray conversion per REQ-013 is compiled in.
REQ-031 Macro SOBEL_GRAY_CONV_EN undefined: no conversion logic; gray = in_dout[7:0], in_dout[23:8] ignored; all other behaviour identical.

Verification
REQ-032 WIDTH=8, HEIGHT=8, all pixels RGB(100,100,100) -> 64 outputs, all 0.
REQ-033 8x8, cols 0-3 RGB(0,0,0), cols 4-7 RGB(255,255,255) -> rows 1-6 cols 3,4 output 255, all else 0; 64 outputs total.
REQ-034 REQ-033 stimulus with out_full held 1 for 20 cycles at output 30 -> in_rd_en=0 and out_wr_en=0 during hold, sequence identical to REQ-033.
REQ-035 REQ-033 stimulus with in_empty randomly 1 at 50% and two back-to-back frames -> 128 outputs, each frame identical to REQ-033.
REQ-036 rst pulsed for 1 cycle after 30 pixels accepted -> out_wr_en=0 next cycle; a following full frame yields exactly 64 outputs matching REQ-033.
REQ-037 THRESHOLD=128, input 8x8 cols 0-3 gray 0, cols 4-7 gray 40 (Gx=160) -> rows 1-6 cols 3,4 output 255, else 0; with SOBEL_GRAY_CONV_EN undefined and in_dout={16'hFFFF, gray} same result.
